// File: rtl/vga_timing_gen_if.sv
// Timing bus between the VGA timing generator (master) and its consumers
// (slave). The consumer side owns the run enable; the generator drives the
// pixel strobe, counters, blanking flags, syncs and prefetch information.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          en;
  logic          pix_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] y_look;
  logic          hbright;
  logic          vbright;
  logic          bright;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic          vlookahead;
  logic [15:0]   frame_count;

  modport master (
    input  en,
    output pix_en, x, y, y_look, hbright, vbright, bright,
           hsync, vsync, line_start, frame_start, vlookahead, frame_count
  );

  modport slave (
    output en,
    input  pix_en, x, y, y_look, hbright, vbright, bright,
           hsync, vsync, line_start, frame_start, vlookahead, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: clock divider producing pixel slots, horizontal and
// vertical counters, blanking/sync decode and a line-prefetch pointer.
// All decode comes from the registered divider/counters; en and rst only
// gate the pixel strobe and blank the display while low.
// Optional feature: define VGA_FRAME_COUNT_EN to build the 16-bit completed
// frame counter; otherwise frame_count is tied to zero.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 29,
  parameter int   CLK_DIV   = 2,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOOKAHEAD = 1,
  parameter int   CW        = 10
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // Compare thresholds carry one extra bit so a sync window ending exactly at
  // 2^CW still fits.
  localparam logic [CW:0] H_ACT_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG_W = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END_W = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG_W = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END_W = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] V_TOT_W  = (CW+1)'(V_TOTAL);
  localparam logic [CW:0] LOOK_W   = (CW+1)'(LOOKAHEAD);

  logic [3:0]    div_cnt_r;
  logic [CW-1:0] hcount_r;
  logic [CW-1:0] vcount_r;

  logic          run_s;
  logic [CW:0]   h_ext_s;
  logic [CW:0]   v_ext_s;
  logic          pix_en_s;
  logic          hbright_s;
  logic          vbright_s;
  logic          hsync_s;
  logic          vsync_s;
  logic          line_start_s;
  logic          frame_start_s;
  logic [CW:0]   look_sum_s;
  logic [CW-1:0] y_look_s;
  logic          vlookahead_s;

  // Divider and raster counters advance only while enabled; frozen otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= 4'd0;
      hcount_r  <= {CW{1'b0}};
      vcount_r  <= {CW{1'b0}};
    end else if (vga.en) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= 4'd0;
        if (hcount_r == H_LAST) begin
          hcount_r <= {CW{1'b0}};
          if (vcount_r == V_LAST) begin
            vcount_r <= {CW{1'b0}};
          end else begin
            vcount_r <= vcount_r + CW'(1);
          end
        end else begin
          hcount_r <= hcount_r + CW'(1);
        end
      end else begin
        div_cnt_r <= div_cnt_r + 4'd1;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
      hcount_r  <= hcount_r;
      vcount_r  <= vcount_r;
    end
  end

  // Pixel strobe, blanking and sync decode; idle (blank, syncs inactive) while
  // disabled or held in reset.
  always_comb begin
    run_s         = vga.en & rst;
    h_ext_s       = {1'b0, hcount_r};
    v_ext_s       = {1'b0, vcount_r};
    pix_en_s      = 1'b0;
    hbright_s     = 1'b0;
    vbright_s     = 1'b0;
    hsync_s       = ~HS_POL;
    vsync_s       = ~VS_POL;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;
    if (run_s) begin
      pix_en_s      = (div_cnt_r == DIV_LAST);
      hbright_s     = (h_ext_s < H_ACT_W);
      vbright_s     = (v_ext_s < V_ACT_W);
      hsync_s       = ((h_ext_s >= HS_BEG_W) && (h_ext_s < HS_END_W)) ? HS_POL : ~HS_POL;
      vsync_s       = ((v_ext_s >= VS_BEG_W) && (v_ext_s < VS_END_W)) ? VS_POL : ~VS_POL;
      line_start_s  = pix_en_s && (hcount_r == {CW{1'b0}});
      frame_start_s = line_start_s && (vcount_r == {CW{1'b0}});
    end else begin
      pix_en_s      = 1'b0;
      hbright_s     = 1'b0;
      vbright_s     = 1'b0;
      hsync_s       = ~HS_POL;
      vsync_s       = ~VS_POL;
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end
  end

  // Prefetch line pointer: vcount + LOOKAHEAD wrapped at V_TOTAL, using one
  // spare bit so the sum never overflows before the wrap.
  always_comb begin
    look_sum_s   = {1'b0, vcount_r} + LOOK_W;
    y_look_s     = {CW{1'b0}};
    vlookahead_s = 1'b0;
    if (look_sum_s >= V_TOT_W) begin
      y_look_s = CW'(look_sum_s - V_TOT_W);
    end else begin
      y_look_s = CW'(look_sum_s);
    end
    if (rst) begin
      vlookahead_s = ({1'b0, y_look_s} < V_ACT_W);
    end else begin
      vlookahead_s = 1'b0;
    end
  end

  assign vga.pix_en      = pix_en_s;
  assign vga.x           = hcount_r;
  assign vga.y           = vcount_r;
  assign vga.y_look      = y_look_s;
  assign vga.hbright     = hbright_s;
  assign vga.vbright     = vbright_s;
  assign vga.bright      = hbright_s & vbright_s;
  assign vga.hsync       = hsync_s;
  assign vga.vsync       = vsync_s;
  assign vga.line_start  = line_start_s;
  assign vga.frame_start = frame_start_s;
  assign vga.vlookahead  = vlookahead_s;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_r;
  logic        seen_frame_r;

  // Count completed frames: the first frame_start after reset only arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count_r <= 16'd0;
      seen_frame_r  <= 1'b0;
    end else if (frame_start_s) begin
      seen_frame_r <= 1'b1;
      if (seen_frame_r) begin
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        frame_count_r <= frame_count_r;
      end
    end else begin
      frame_count_r <= frame_count_r;
      seen_frame_r  <= seen_frame_r;
    end
  end

  assign vga.frame_count = frame_count_r;
`else
  assign vga.frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-parameter instance (CLK_DIV=2,
// active-low syncs) and a small-raster instance (CLK_DIV=1, active-high syncs,
// LOOKAHEAD=3) checked cycle by cycle against hand-derived raster positions.
module tb_vga_timing_gen;

  logic clk;
  logic rst0;
  logic rst1;
  int   n_checks;
  int   n_fail;

  vga_timing_gen_if #(.CW(10)) v0 ();
  vga_timing_gen_if #(.CW(5))  v1 ();

  vga_timing_gen u_dut0 (
    .clk (clk),
    .rst (rst0),
    .vga (v0)
  );

  // Small raster: H 8/2/3/3 (total 16), V 6/1/2/2 (total 11).
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .CLK_DIV (1), .HS_POL (1'b1), .VS_POL (1'b1),
    .LOOKAHEAD (3), .CW (5)
  ) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .vga (v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_x(input int tx);
    int n;
    n = 0;
    while (int'(v0.x) != tx && n < 4000) begin
      tick();
      n++;
    end
    chk("reach_x", int'(v0.x), tx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, nhs, bad;
    int h, v, e_hs, e_vs, e_br, e_ls, e_fs, e_yl, e_vl, e_fc;
    n_checks = 0;
    n_fail   = 0;
    rst0     = 1'b0;
    rst1     = 1'b0;
    v0.en    = 1'b1;
    v1.en    = 1'b1;
    tick();
    tick();

    // Reset values, default instance
    chk("rst_pix_en",  32'(v0.pix_en), 0);
    chk("rst_x",       32'(v0.x), 0);
    chk("rst_y",       32'(v0.y), 0);
    chk("rst_bright",  32'(v0.bright), 0);
    chk("rst_hbright", 32'(v0.hbright), 0);
    chk("rst_vbright", 32'(v0.vbright), 0);
    chk("rst_hsync",   32'(v0.hsync), 1);
    chk("rst_vsync",   32'(v0.vsync), 1);
    chk("rst_ls",      32'(v0.line_start), 0);
    chk("rst_fs",      32'(v0.frame_start), 0);
    chk("rst_vlook",   32'(v0.vlookahead), 0);
    chk("rst_fcount",  32'(v0.frame_count), 0);
    // Reset values, active-high sync instance
    chk("rst1_pix_en", 32'(v1.pix_en), 0);
    chk("rst1_hsync",  32'(v1.hsync), 0);
    chk("rst1_vsync",  32'(v1.vsync), 0);
    chk("rst1_bright", 32'(v1.bright), 0);

    // Release: first pix_en is sampled on the 2nd edge and carries frame_start
    rst0 = 1'b1;
    #1;
    chk("rel_pix_en0", 32'(v0.pix_en), 0);
    chk("rel_fs0",     32'(v0.frame_start), 0);
    chk("rel_ylook",   32'(v0.y_look), 1);
    chk("rel_vlook",   32'(v0.vlookahead), 1);
    chk("rel_bright",  32'(v0.bright), 1);
    tick();
    chk("rel_pix_en1", 32'(v0.pix_en), 1);
    chk("rel_fs1",     32'(v0.frame_start), 1);
    chk("rel_ls1",     32'(v0.line_start), 1);
    chk("rel_x1",      32'(v0.x), 0);
    tick();
    chk("rel_x2",      32'(v0.x), 1);
    chk("rel_pix_en2", 32'(v0.pix_en), 0);
    chk("rel_fs2",     32'(v0.frame_start), 0);

    // Freeze at hcount 639 for 37 clocks
    goto_x(639);
    v0.en = 1'b0;
    #1;
    chk("frz_pix_en",  32'(v0.pix_en), 0);
    chk("frz_bright",  32'(v0.bright), 0);
    chk("frz_hbright", 32'(v0.hbright), 0);
    chk("frz_vbright", 32'(v0.vbright), 0);
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if (int'(v0.x) != 639 || int'(v0.y) != 0 || v0.bright || v0.pix_en ||
          v0.hbright || v0.vbright || !v0.hsync) bad++;
    end
    chk("frz_bad_cycles", bad, 0);
    v0.en = 1'b1;
    #1;
    chk("resume_pix_en0", 32'(v0.pix_en), 0);
    chk("resume_x0",      32'(v0.x), 639);
    chk("resume_bright",  32'(v0.bright), 1);
    tick();
    chk("resume_pix_en1", 32'(v0.pix_en), 1);
    chk("resume_x1",      32'(v0.x), 639);
    tick();
    chk("resume_x2",      32'(v0.x), 640);
    chk("x640_hbright",   32'(v0.hbright), 0);
    chk("x640_bright",    32'(v0.bright), 0);
    chk("x640_vbright",   32'(v0.vbright), 1);

    // Horizontal sync window edges (active-low)
    goto_x(655);
    chk("hs_655", 32'(v0.hsync), 1);
    goto_x(656);
    chk("hs_656", 32'(v0.hsync), 0);
    goto_x(751);
    chk("hs_751", 32'(v0.hsync), 0);
    goto_x(752);
    chk("hs_752", 32'(v0.hsync), 1);

    // Next line_start, then measure one full line
    n = 0;
    while (!v0.line_start && n < 2000) begin
      tick();
      n++;
    end
    chk("ls_seen",    32'(v0.line_start), 1);
    chk("ls_y",       32'(v0.y), 1);
    chk("ls_x",       32'(v0.x), 0);
    chk("ls_fs",      32'(v0.frame_start), 0);
    chk("ls_ylook",   32'(v0.y_look), 2);
    chk("ls_vlook",   32'(v0.vlookahead), 1);
    n = 0;
    nb = 0;
    nhs = 0;
    do begin
      tick();
      n++;
      if (v0.pix_en && v0.bright) nb++;
      if (!v0.hsync) nhs++;
    end while (!v0.line_start && n < 3000);
    chk("line_period",   n, 1600);
    chk("line_bright",   nb, 640);
    chk("line_hs_clks",  nhs, 192);
    chk("line2_y",       32'(v0.y), 2);
    tick();
    chk("ls_width",      32'(v0.line_start), 0);
    chk("ls_next_x",     32'(v0.x), 1);

    // Syncs go inactive while disabled inside the sync window
    goto_x(700);
    chk("x700_hsync", 32'(v0.hsync), 0);
    v0.en = 1'b0;
    #1;
    chk("dis_hsync",  32'(v0.hsync), 1);
    v0.en = 1'b1;
    #1;
    chk("en_hsync",   32'(v0.hsync), 0);

    // Asynchronous reset mid-line: no clock edge between assert and check
    #3;
    rst0 = 1'b0;
    #1;
    chk("arst_x",      32'(v0.x), 0);
    chk("arst_y",      32'(v0.y), 0);
    chk("arst_pix_en", 32'(v0.pix_en), 0);
    chk("arst_hsync",  32'(v0.hsync), 1);
    chk("arst_bright", 32'(v0.bright), 0);
    chk("arst_vlook",  32'(v0.vlookahead), 0);
    chk("arst_fcount", 32'(v0.frame_count), 0);
    tick();
    rst0 = 1'b1;
    #1;
    chk("arel_fs0", 32'(v0.frame_start), 0);
    tick();
    chk("arel_fs1",     32'(v0.frame_start), 1);
    chk("arel_pix_en1", 32'(v0.pix_en), 1);
    tick();
    chk("arel_fs2",     32'(v0.frame_start), 0);
    chk("arel_x2",      32'(v0.x), 1);

    // Small raster, CLK_DIV=1: position after k edges is h=k%16, v=(k/16)%11
    rst1 = 1'b1;
    #1;
    for (int k = 0; k < 720; k++) begin
      if (k > 0) tick();
      h    = k % 16;
      v    = (k / 16) % 11;
      e_hs = (h >= 10 && h < 13) ? 1 : 0;
      e_vs = (v >= 7 && v < 9) ? 1 : 0;
      e_br = (h < 8 && v < 6) ? 1 : 0;
      e_ls = (h == 0) ? 1 : 0;
      e_fs = (h == 0 && v == 0) ? 1 : 0;
      e_yl = (v + 3) % 11;
      e_vl = (e_yl < 6) ? 1 : 0;
`ifdef VGA_FRAME_COUNT_EN
      e_fc = (k == 0) ? 0 : (k - 1) / 176;
`else
      e_fc = 0;
`endif
      chk("d1_pix_en", 32'(v1.pix_en), 1);
      chk("d1_x",      32'(v1.x), h);
      chk("d1_y",      32'(v1.y), v);
      chk("d1_hsync",  32'(v1.hsync), e_hs);
      chk("d1_vsync",  32'(v1.vsync), e_vs);
      chk("d1_bright", 32'(v1.bright), e_br);
      chk("d1_ls",     32'(v1.line_start), e_ls);
      chk("d1_fs",     32'(v1.frame_start), e_fs);
      chk("d1_ylook",  32'(v1.y_look), e_yl);
      chk("d1_vlook",  32'(v1.vlookahead), e_vl);
      chk("d1_fcount", 32'(v1.frame_count), e_fc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
